nalu_parser_sched: RTL and testbench

Dispatches header parsing for each NAL unit. It sits between the byte-window bit aligner and the VPS/SPS/PPS/slice-header parsers. On each NAL start it reads the 2-byte NAL unit header itself and decodes `nal_unit_type`. It then resets and enables exactly one parser and routes that parser's `forward_len` back to the aligner until the parser signals completion. It also reports skipped NALs, header errors, preemption and hung parsers.

---
 rtl/nalu_parser_sched.sv | 200 ++++++++++++++++++++
 tb/tb_nalu_parser_sched.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nalu_parser_sched.sv
// NAL unit header scheduler: reads the 2-byte NAL header, dispatches one of VPS/SPS/PPS/slice
// parsers and reports skip/error/preempt. Build with NALU_WATCHDOG_EN to add the RUN watchdog.
module nalu_parser_sched #(
   parameter int unsigned WDOG_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_nal_start,
   input  logic [7:0]  i_rbsp_in,
   input  logic [15:0] i_parser_fwd_len,
   input  logic [3:0]  i_parser_done,
   output logic [3:0]  o_parser_en,
   output logic [3:0]  o_parser_rst,
   output logic [3:0]  o_forward_len,
   output logic [5:0]  o_nal_unit_type,
   output logic [2:0]  o_temporal_id,
   output logic        o_busy,
   output logic        o_nal_done,
   output logic        o_nal_skipped,
   output logic        o_err,
   output logic [1:0]  o_err_code
);

   typedef enum logic [2:0] {
      StIdle, StHdr0, StWait0, StHdr1, StWait1, StDispatch, StRun
   } state_e;

   state_e      r_state, w_state_d;
   logic [3:0]  r_fwd, w_fwd_d;
   logic [5:0]  r_type, w_type_d;
   logic        r_forbid, w_forbid_d;
   logic [2:0]  r_tid, w_tid_d;
   logic [1:0]  r_k, w_k_d;
   logic [3:0]  r_prst, w_prst_d;
   logic        r_done, w_done_d;
   logic        r_skip, w_skip_d;
   logic        r_err, w_err_d;
   logic [1:0]  r_err_code, w_err_code_d;

   logic        w_preempt;
   logic [3:0]  w_run_onehot;
   logic [3:0]  w_run_fwd;
   logic [3:0]  w_dispatch_rst;
   logic        w_dec_ok;
   logic [1:0]  w_dec_k;
   logic        w_wdog_hit;

`ifdef NALU_WATCHDOG_EN
   localparam logic [15:0] WdogLast = 16'(WDOG_CYCLES - 1);
   logic [15:0] r_wdog, w_wdog_d;

   assign w_wdog_hit = (r_wdog == WdogLast);

   always_ff @(posedge clk) begin
      if (!rst_n) r_wdog <= '0;
      else        r_wdog <= w_wdog_d;
   end
`else
   logic w_unused_wdog;

   assign w_wdog_hit    = 1'b0;
   assign w_unused_wdog = (WDOG_CYCLES != 0);
`endif

   assign w_preempt    = i_nal_start && (r_state != StIdle);
   assign w_run_onehot = 4'b0001 << r_k;
   assign w_run_fwd    = i_parser_fwd_len[{r_k, 2'b00} +: 4];

   always_comb begin
      w_dec_ok = 1'b1;
      w_dec_k  = 2'd3;
      if (r_type == 6'd32)      w_dec_k = 2'd0;
      else if (r_type == 6'd33) w_dec_k = 2'd1;
      else if (r_type == 6'd34) w_dec_k = 2'd2;
      else if (!(r_type inside {[6'd0:6'd9], [6'd16:6'd21]})) w_dec_ok = 1'b0;
   end

   always_comb begin
      w_state_d      = r_state;
      w_fwd_d        = 4'd0;
      w_type_d       = r_type;
      w_forbid_d     = r_forbid;
      w_tid_d        = r_tid;
      w_k_d          = r_k;
      w_prst_d       = 4'd0;
      w_done_d       = 1'b0;
      w_skip_d       = 1'b0;
      w_err_d        = 1'b0;
      w_err_code_d   = r_err_code;
      w_dispatch_rst = 4'd0;
`ifdef NALU_WATCHDOG_EN
      w_wdog_d       = r_wdog;
`endif
      // A new NAL start outside RUN abandons the header in flight.
      if (w_preempt && (r_state != StRun)) begin
         w_err_d      = 1'b1;
         w_err_code_d = 2'd3;
         w_state_d    = StHdr0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_nal_start) w_state_d = StHdr0;
            end
            StHdr0: begin
               w_forbid_d = i_rbsp_in[7];
               w_type_d   = i_rbsp_in[6:1];
               w_fwd_d    = 4'd8;
               w_state_d  = StWait0;
            end
            StWait0: w_state_d = StHdr1;
            StHdr1: begin
               w_tid_d   = i_rbsp_in[2:0] - 3'd1;
               w_fwd_d   = 4'd8;
               w_state_d = StWait1;
            end
            StWait1: w_state_d = StDispatch;
            StDispatch: begin
               if (r_forbid) begin
                  w_err_d      = 1'b1;
                  w_err_code_d = 2'd1;
                  w_state_d    = StIdle;
               end else if (w_dec_ok) begin
                  w_k_d          = w_dec_k;
                  w_dispatch_rst = 4'b0001 << w_dec_k;
                  w_state_d      = StRun;
`ifdef NALU_WATCHDOG_EN
                  w_wdog_d       = '0;
`endif
               end else begin
                  w_skip_d  = 1'b1;
                  w_state_d = StIdle;
               end
            end
            StRun: begin
               // Completion beats a coincident start; the new header still begins next cycle.
               if (i_parser_done[r_k]) begin
                  w_done_d  = 1'b1;
                  w_state_d = i_nal_start ? StHdr0 : StIdle;
               end else if (i_nal_start) begin
                  w_err_d      = 1'b1;
                  w_err_code_d = 2'd3;
                  w_prst_d     = w_run_onehot;
                  w_state_d    = StHdr0;
               end else if (w_wdog_hit) begin
                  w_err_d      = 1'b1;
                  w_err_code_d = 2'd2;
                  w_prst_d     = w_run_onehot;
                  w_state_d    = StIdle;
               end else begin
`ifdef NALU_WATCHDOG_EN
                  w_wdog_d = r_wdog + 16'd1;
`endif
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_fwd      <= 4'd0;
         r_type     <= 6'd0;
         r_forbid   <= 1'b0;
         r_tid      <= 3'd0;
         r_k        <= 2'd0;
         r_prst     <= 4'hF;
         r_done     <= 1'b0;
         r_skip     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 2'd0;
      end else begin
         r_state    <= w_state_d;
         r_fwd      <= w_fwd_d;
         r_type     <= w_type_d;
         r_forbid   <= w_forbid_d;
         r_tid      <= w_tid_d;
         r_k        <= w_k_d;
         r_prst     <= w_prst_d;
         r_done     <= w_done_d;
         r_skip     <= w_skip_d;
         r_err      <= w_err_d;
         r_err_code <= w_err_code_d;
      end
   end

   // Parser lengths pass straight through in RUN: parsers rely on a one-cycle aligner turnaround.
   assign o_forward_len   = w_preempt ? 4'd0 : ((r_state == StRun) ? w_run_fwd : r_fwd);
   assign o_parser_en     = (r_state == StRun) ? w_run_onehot : 4'd0;
   assign o_parser_rst    = r_prst | w_dispatch_rst;
   assign o_nal_unit_type = r_type;
   assign o_temporal_id   = r_tid;
   assign o_busy          = (r_state != StIdle);
   assign o_nal_done      = r_done;
   assign o_nal_skipped   = r_skip;
   assign o_err           = r_err;
   assign o_err_code      = r_err_code;

endmodule

// File: tb/tb_nalu_parser_sched.sv
// Directed bench for nalu_parser_sched; a second WDOG_CYCLES=16 instance is checked when
// NALU_WATCHDOG_EN is defined.
module tb_nalu_parser_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_nal_start = 1'b0;
   logic [7:0]  i_rbsp_in = 8'h00;
   logic [15:0] i_parser_fwd_len = 16'h0000;
   logic [3:0]  i_parser_done = 4'h0;
   logic [3:0]  o_parser_en, o_parser_rst, o_forward_len;
   logic [5:0]  o_nal_unit_type;
   logic [2:0]  o_temporal_id;
   logic        o_busy, o_nal_done, o_nal_skipped, o_err;
   logic [1:0]  o_err_code;

   int n_checks = 0;
   int n_pass   = 0;
   logic [3:0] fwd_log [4];
   logic [3:0] rst_log;

   always #5 clk = ~clk;

   nalu_parser_sched #(.WDOG_CYCLES(4096)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_nal_start      (i_nal_start),
      .i_rbsp_in        (i_rbsp_in),
      .i_parser_fwd_len (i_parser_fwd_len),
      .i_parser_done    (i_parser_done),
      .o_parser_en      (o_parser_en),
      .o_parser_rst     (o_parser_rst),
      .o_forward_len    (o_forward_len),
      .o_nal_unit_type  (o_nal_unit_type),
      .o_temporal_id    (o_temporal_id),
      .o_busy           (o_busy),
      .o_nal_done       (o_nal_done),
      .o_nal_skipped    (o_nal_skipped),
      .o_err            (o_err),
      .o_err_code       (o_err_code)
   );

`ifdef NALU_WATCHDOG_EN
   logic [3:0] wd_parser_en, wd_parser_rst, wd_forward_len;
   logic [5:0] wd_nal_unit_type;
   logic [2:0] wd_temporal_id;
   logic       wd_busy, wd_nal_done, wd_nal_skipped, wd_err;
   logic [1:0] wd_err_code;

   nalu_parser_sched #(.WDOG_CYCLES(16)) dut_wd (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_nal_start      (i_nal_start),
      .i_rbsp_in        (i_rbsp_in),
      .i_parser_fwd_len (i_parser_fwd_len),
      .i_parser_done    (i_parser_done),
      .o_parser_en      (wd_parser_en),
      .o_parser_rst     (wd_parser_rst),
      .o_forward_len    (wd_forward_len),
      .o_nal_unit_type  (wd_nal_unit_type),
      .o_temporal_id    (wd_temporal_id),
      .o_busy           (wd_busy),
      .o_nal_done       (wd_nal_done),
      .o_nal_skipped    (wd_nal_skipped),
      .o_err            (wd_err),
      .o_err_code       (wd_err_code)
   );
`endif

   // Inputs change just after the rising edge; outputs are read on the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Pulses start, feeds the two header bytes, and stops at mid-cycle of DISPATCH.
   task automatic drive_header(input logic [7:0] b0, input logic [7:0] b1);
      next_cycle();
      i_nal_start = 1'b1;
      next_cycle();
      i_nal_start = 1'b0;
      i_rbsp_in   = b0;
      next_cycle();
      sample();
      fwd_log[0] = o_forward_len;
      next_cycle();
      i_rbsp_in = b1;
      sample();
      fwd_log[1] = o_forward_len;
      next_cycle();
      sample();
      fwd_log[2] = o_forward_len;
      next_cycle();
      sample();
      fwd_log[3] = o_forward_len;
      rst_log    = o_parser_rst;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) next_cycle();
      sample();
      n_checks++;
      if (o_parser_rst !== 4'hF) $display("FAIL reset_parser_rst: got %h want F", o_parser_rst);
      else n_pass++;
      n_checks++;
      if ({o_parser_en, o_forward_len} !== 8'h00)
         $display("FAIL reset_en_fwd: got %h want 00", {o_parser_en, o_forward_len});
      else n_pass++;
      n_checks++;
      if ({o_nal_unit_type, o_temporal_id, o_err_code} !== 11'd0)
         $display("FAIL reset_hdr_fields: got %h want 0", {o_nal_unit_type, o_temporal_id, o_err_code});
      else n_pass++;
      n_checks++;
      if ({o_busy, o_nal_done, o_nal_skipped, o_err} !== 4'b0000)
         $display("FAIL reset_flags: got %b want 0000", {o_busy, o_nal_done, o_nal_skipped, o_err});
      else n_pass++;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      sample();
      n_checks++;
      if (o_parser_rst !== 4'h0) $display("FAIL reset_release: got %h want 0", o_parser_rst);
      else n_pass++;
   endtask

   task automatic test_pps();
      logic [3:0] seen [3];
      int pulses = 0;
      drive_header(8'h44, 8'h01);
      n_checks++;
      if ({fwd_log[0], fwd_log[1], fwd_log[2], fwd_log[3]} !== 16'h8080)
         $display("FAIL pps_hdr_fwd: got %h want 8080",
                  {fwd_log[0], fwd_log[1], fwd_log[2], fwd_log[3]});
      else n_pass++;
      n_checks++;
      if (rst_log !== 4'b0100) $display("FAIL pps_parser_rst: got %b want 0100", rst_log);
      else n_pass++;
      n_checks++;
      if (o_nal_unit_type !== 6'd34) $display("FAIL pps_type: got %0d want 34", o_nal_unit_type);
      else n_pass++;
      n_checks++;
      if (o_temporal_id !== 3'd0) $display("FAIL pps_tid: got %0d want 0", o_temporal_id);
      else n_pass++;
      for (int i = 0; i <= 40; i++) begin
         next_cycle();
         // Fields of the other parsers carry junk that must be ignored.
         i_parser_fwd_len = {4'hF, (i == 0) ? 4'd7 : (i == 1) ? 4'd3 : (i == 2) ? 4'd8 : 4'd0,
                             4'hF, 4'hF};
         i_parser_done = (i == 40) ? 4'b0100 : ((i >= 3) ? 4'b1011 : 4'b0000);
         sample();
         if (i < 3) seen[i] = o_forward_len;
         if (i == 0) begin
            n_checks++;
            if ({o_parser_en, o_parser_rst} !== 8'b0100_0000)
               $display("FAIL pps_run_en: got en=%b rst=%b want en=0100 rst=0000",
                        o_parser_en, o_parser_rst);
            else n_pass++;
         end
         if (i == 5) begin
            n_checks++;
            if (o_forward_len !== 4'd0) $display("FAIL pps_unused_fwd: got %0d want 0", o_forward_len);
            else n_pass++;
         end
         if (i == 39) begin
            n_checks++;
            if (o_busy !== 1'b1) $display("FAIL pps_other_done_ignored: busy got %b want 1", o_busy);
            else n_pass++;
         end
         pulses += int'(o_nal_done);
      end
      n_checks++;
      if ({seen[0], seen[1], seen[2]} !== 12'h738)
         $display("FAIL pps_run_fwd: got %h want 738", {seen[0], seen[1], seen[2]});
      else n_pass++;
      next_cycle();
      i_parser_fwd_len = 16'h0000;
      i_parser_done    = 4'h0;
      sample();
      pulses += int'(o_nal_done);
      n_checks++;
      if ({o_nal_done, o_parser_en, o_busy} !== 6'b1_0000_0)
         $display("FAIL pps_done: got done=%b en=%b busy=%b want 1 0000 0",
                  o_nal_done, o_parser_en, o_busy);
      else n_pass++;
      next_cycle();
      sample();
      pulses += int'(o_nal_done);
      n_checks++;
      if (pulses !== 1) $display("FAIL pps_done_count: got %0d want 1", pulses);
      else n_pass++;
   endtask

   task automatic test_slice19();
      drive_header(8'h26, 8'h01);
      n_checks++;
      if (rst_log !== 4'b1000) $display("FAIL slice_parser_rst: got %b want 1000", rst_log);
      else n_pass++;
      n_checks++;
      if (o_nal_unit_type !== 6'd19) $display("FAIL slice_type: got %0d want 19", o_nal_unit_type);
      else n_pass++;
      next_cycle();
      i_parser_done = 4'b1000;
      sample();
      n_checks++;
      if (o_parser_en !== 4'b1000) $display("FAIL slice_en: got %b want 1000", o_parser_en);
      else n_pass++;
      next_cycle();
      i_parser_done = 4'b0000;
      sample();
      n_checks++;
      if (o_nal_done !== 1'b1) $display("FAIL slice_done: got %b want 1", o_nal_done);
      else n_pass++;
   endtask

   task automatic test_skip();
      drive_header(8'h4E, 8'h01);
      n_checks++;
      if ({rst_log, o_busy} !== 5'b0000_1)
         $display("FAIL skip_dispatch: got rst=%b busy=%b want 0000 1", rst_log, o_busy);
      else n_pass++;
      next_cycle();
      sample();
      n_checks++;
      if ({o_nal_skipped, o_busy, o_parser_en} !== 6'b1_0_0000)
         $display("FAIL skip_pulse: got skip=%b busy=%b en=%b want 1 0 0000",
                  o_nal_skipped, o_busy, o_parser_en);
      else n_pass++;
      n_checks++;
      if (o_nal_unit_type !== 6'd39) $display("FAIL skip_type: got %0d want 39", o_nal_unit_type);
      else n_pass++;
   endtask

   task automatic test_forbidden();
      drive_header(8'hC4, 8'h01);
      n_checks++;
      if (rst_log !== 4'b0000) $display("FAIL forbid_no_rst: got %b want 0000", rst_log);
      else n_pass++;
      next_cycle();
      sample();
      n_checks++;
      if ({o_err, o_err_code} !== 3'b1_01)
         $display("FAIL forbid_err: got err=%b code=%0d want 1 1", o_err, o_err_code);
      else n_pass++;
      n_checks++;
      if ({o_busy, o_parser_en, o_parser_rst} !== 9'b0_0000_0000)
         $display("FAIL forbid_idle: got busy=%b en=%b rst=%b want 0 0000 0000",
                  o_busy, o_parser_en, o_parser_rst);
      else n_pass++;
   endtask

   task automatic test_preempt();
      drive_header(8'h42, 8'h03);
      n_checks++;
      if (rst_log !== 4'b0010) $display("FAIL preempt_sps_rst: got %b want 0010", rst_log);
      else n_pass++;
      n_checks++;
      if (o_temporal_id !== 3'd2) $display("FAIL preempt_tid: got %0d want 2", o_temporal_id);
      else n_pass++;
      for (int i = 0; i <= 10; i++) begin
         next_cycle();
         i_parser_fwd_len = 16'h0050;
         i_nal_start      = (i == 10);
         sample();
         if (i == 9) begin
            n_checks++;
            if ({o_parser_en, o_forward_len} !== 8'b0010_0101)
               $display("FAIL preempt_run: got en=%b fwd=%0d want 0010 5", o_parser_en, o_forward_len);
            else n_pass++;
         end
         if (i == 10) begin
            n_checks++;
            if (o_forward_len !== 4'd0) $display("FAIL preempt_fwd_kill: got %0d want 0", o_forward_len);
            else n_pass++;
         end
      end
      next_cycle();
      i_nal_start      = 1'b0;
      i_parser_fwd_len = 16'h0000;
      i_rbsp_in        = 8'h26;
      sample();
      n_checks++;
      if ({o_err, o_err_code, o_parser_rst} !== 7'b1_11_0010)
         $display("FAIL preempt_err: got err=%b code=%0d rst=%b want 1 3 0010",
                  o_err, o_err_code, o_parser_rst);
      else n_pass++;
      n_checks++;
      if ({o_busy, o_parser_en} !== 5'b1_0000)
         $display("FAIL preempt_hdr0: got busy=%b en=%b want 1 0000", o_busy, o_parser_en);
      else n_pass++;
      next_cycle();
      sample();
      n_checks++;
      if ({o_forward_len, o_nal_unit_type, o_err} !== {4'd8, 6'd19, 1'b0})
         $display("FAIL preempt_new_hdr: got fwd=%0d type=%0d err=%b want 8 19 0",
                  o_forward_len, o_nal_unit_type, o_err);
      else n_pass++;
      next_cycle();
      i_rbsp_in = 8'h01;
      next_cycle();
      next_cycle();
      next_cycle();
      i_parser_done = 4'b1000;
      sample();
      n_checks++;
      if (o_parser_en !== 4'b1000) $display("FAIL preempt_next_en: got %b want 1000", o_parser_en);
      else n_pass++;
      next_cycle();
      i_parser_done = 4'b0000;
      sample();
      n_checks++;
      if (o_nal_done !== 1'b1) $display("FAIL preempt_next_done: got %b want 1", o_nal_done);
      else n_pass++;
   endtask

   task automatic test_done_and_start();
      drive_header(8'h42, 8'h01);
      for (int i = 0; i <= 10; i++) begin
         next_cycle();
         i_parser_fwd_len = 16'h0000;
         i_nal_start      = (i == 10);
         i_parser_done    = (i == 10) ? 4'b0010 : 4'b0000;
         sample();
         if (i == 10) begin
            n_checks++;
            if (o_forward_len !== 4'd0) $display("FAIL both_fwd: got %0d want 0", o_forward_len);
            else n_pass++;
         end
      end
      next_cycle();
      i_nal_start   = 1'b0;
      i_parser_done = 4'b0000;
      i_rbsp_in     = 8'h4E;
      sample();
      n_checks++;
      if ({o_nal_done, o_err, o_busy} !== 3'b1_0_1)
         $display("FAIL both_done_wins: got done=%b err=%b busy=%b want 1 0 1",
                  o_nal_done, o_err, o_busy);
      else n_pass++;
      n_checks++;
      if (o_err_code !== 2'd3) $display("FAIL both_code_held: got %0d want 3", o_err_code);
      else n_pass++;
      next_cycle();
      next_cycle();
      i_rbsp_in = 8'h01;
      next_cycle();
      next_cycle();
      next_cycle();
      sample();
      n_checks++;
      if ({o_nal_skipped, o_busy} !== 2'b10)
         $display("FAIL both_then_skip: got skip=%b busy=%b want 1 0", o_nal_skipped, o_busy);
      else n_pass++;
   endtask

   task automatic test_watchdog();
      drive_header(8'h42, 8'h01);
`ifdef NALU_WATCHDOG_EN
      for (int i = 0; i <= 15; i++) begin
         next_cycle();
         sample();
         if (i == 15) begin
            n_checks++;
            if ({wd_err, wd_busy, wd_parser_en} !== 6'b0_1_0010)
               $display("FAIL wdog_before: got err=%b busy=%b en=%b want 0 1 0010",
                        wd_err, wd_busy, wd_parser_en);
            else n_pass++;
         end
      end
      next_cycle();
      sample();
      n_checks++;
      if ({wd_err, wd_err_code, wd_parser_rst} !== 7'b1_10_0010)
         $display("FAIL wdog_fire: got err=%b code=%0d rst=%b want 1 2 0010",
                  wd_err, wd_err_code, wd_parser_rst);
      else n_pass++;
      n_checks++;
      if ({wd_busy, wd_parser_en} !== 5'b0_0000)
         $display("FAIL wdog_idle: got busy=%b en=%b want 0 0000", wd_busy, wd_parser_en);
      else n_pass++;
      n_checks++;
      if ({o_busy, o_err} !== 2'b10)
         $display("FAIL wdog_long_limit: got busy=%b err=%b want 1 0", o_busy, o_err);
      else n_pass++;
`else
      repeat (40) next_cycle();
      sample();
      n_checks++;
      if ({o_busy, o_err, o_parser_en} !== 6'b1_0_0010)
         $display("FAIL nowdog_hold: got busy=%b err=%b en=%b want 1 0 0010",
                  o_busy, o_err, o_parser_en);
      else n_pass++;
`endif
   endtask

   task automatic test_mid_reset();
      drive_header(8'h42, 8'h01);
      next_cycle();
      sample();
      n_checks++;
      if (o_parser_en !== 4'b0010) $display("FAIL midrst_run: got %b want 0010", o_parser_en);
      else n_pass++;
      next_cycle();
      rst_n = 1'b0;
      next_cycle();
      sample();
      n_checks++;
      if ({o_busy, o_parser_en, o_parser_rst, o_forward_len} !== 13'b0_0000_1111_0000)
         $display("FAIL midrst_state: got busy=%b en=%b rst=%b fwd=%0d want 0 0000 1111 0",
                  o_busy, o_parser_en, o_parser_rst, o_forward_len);
      else n_pass++;
      n_checks++;
      if ({o_nal_done, o_nal_skipped, o_err, o_err_code, o_nal_unit_type} !== 11'd0)
         $display("FAIL midrst_outputs: got %b want 0",
                  {o_nal_done, o_nal_skipped, o_err, o_err_code, o_nal_unit_type});
      else n_pass++;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      sample();
      n_checks++;
      if (o_parser_rst !== 4'h0) $display("FAIL midrst_release: got %b want 0000", o_parser_rst);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_pps();
      test_slice19();
      test_skip();
      test_forbidden();
      test_preempt();
      test_done_and_start();
      test_watchdog();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
